// File: rtl/l2_line_adaptor.sv
// l2_line_adaptor: converts L2 256-bit line requests into 4-beat 64-bit memory bursts
module l2_line_adaptor #(
   parameter int s_line  = 256,
   parameter int s_burst = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         line_address,
   input  logic [s_line-1:0]   line_wdata,
   input  logic                line_read,
   input  logic                line_write,
   output logic [s_line-1:0]   line_rdata,
   output logic                line_resp,
   output logic [31:0]         burst_address,
   input  logic [s_burst-1:0]  burst_rdata,
   output logic [s_burst-1:0]  burst_wdata,
   output logic                burst_read,
   output logic                burst_write,
   input  logic                burst_resp
);
   localparam int nbeats = s_line / s_burst;
   localparam int bw = $clog2(nbeats);
   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, RESP} state_t;
   state_t state, next;
   logic [bw-1:0] beat;
   logic [s_line-1:0] wdata_q;
   logic in_burst, last;
   assign in_burst = state == RD_BURST || state == WR_BURST;
   assign last = burst_resp && beat == bw'(nbeats - 1);
   assign burst_read = state == RD_BURST;
   assign burst_write = state == WR_BURST;
   assign line_resp = state == RESP;
   assign burst_wdata = wdata_q[s_burst*beat +: s_burst];
   // state register
   always_ff @(posedge clk)
      state <= rst ? IDLE : next;
   // next state: read wins over write in IDLE, RESP always returns to IDLE
   always_comb begin
      next = state == IDLE ? (line_read ? RD_BURST : line_write ? WR_BURST : IDLE)
           : state == RESP ? IDLE
           : last ? RESP : state;
   end
   // latch request at accept, count beats and assemble read line
   always_ff @(posedge clk)
      if (rst) begin
         beat <= '0;
         line_rdata <= '0;
         burst_address <= '0;
         wdata_q <= '0;
      end else if (state == IDLE) begin
         if (line_read || line_write)
            burst_address <= line_address & ~32'(s_line / 8 - 1);
         if (line_write && !line_read)
            wdata_q <= line_wdata;
      end else if (in_burst && burst_resp) begin
         beat <= beat + 1'b1;
         if (state == RD_BURST)
            line_rdata[s_burst*beat +: s_burst] <= burst_rdata;
      end
endmodule

// File: tb/tb_l2_line_adaptor.sv
// tb_l2_line_adaptor: directed and random line traffic against a line-level memory model
module tb_l2_line_adaptor;
   logic clk = 0, rst;
   logic [31:0] line_address, burst_address;
   logic [255:0] line_wdata, line_rdata;
   logic line_read, line_write, line_resp;
   logic [63:0] burst_rdata, burst_wdata;
   logic burst_read, burst_write, burst_resp;
   int n_chk = 0, n_fail = 0;
   logic [255:0] mem [logic [26:0]];
   logic [255:0] last_rd;

   l2_line_adaptor dut (
      .clk(clk), .rst(rst),
      .line_address(line_address), .line_wdata(line_wdata),
      .line_read(line_read), .line_write(line_write),
      .line_rdata(line_rdata), .line_resp(line_resp),
      .burst_address(burst_address), .burst_rdata(burst_rdata),
      .burst_wdata(burst_wdata), .burst_read(burst_read),
      .burst_write(burst_write), .burst_resp(burst_resp)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
      return l;
   endfunction

   function automatic logic [255:0] line_of(input logic [31:0] a);
      if (!mem.exists(a[31:5])) mem[a[31:5]] = rand_line();
      return mem[a[31:5]];
   endfunction

   // One L2 transaction; the memory side answers beat i with bits 64*i+63:64*i of the line.
   task automatic req(input bit rq, input bit wq, input logic [31:0] a, input logic [255:0] wd,
                      input int gap_at, input bit rnd);
      bit is_rd, gapped, go;
      logic [255:0] exp_line;
      int beats, cyc;
      is_rd = rq;
      exp_line = is_rd ? line_of(a) : wd;
      line_read = rq;
      line_write = wq;
      line_address = a;
      line_wdata = wd;
      tick();
      line_address = $urandom;
      line_wdata = rand_line();
      beats = 0;
      cyc = 0;
      gapped = 0;
      while (line_resp !== 1'b1 && cyc < 40) begin
         chk("burst_read", burst_read, is_rd);
         chk("burst_write", burst_write, !is_rd);
         chk("burst_address", burst_address, {a[31:5], 5'b0});
         if (!is_rd && beats < 4) chk("burst_wdata", burst_wdata, wd[64*beats +: 64]);
         go = beats < 4;
         if (go && beats == gap_at && !gapped) begin
            go = 0;
            gapped = 1;
         end
         if (go && rnd && $urandom_range(0, 2) == 0) go = 0;
         burst_resp = go;
         burst_rdata = go ? exp_line[64*beats +: 64] : 64'({$urandom, $urandom});
         if (go) beats++;
         tick();
         cyc++;
      end
      burst_resp = 0;
      chk("line_resp", line_resp, 1);
      chk("beat_count", beats, 4);
      chk("line_rdata", line_rdata, is_rd ? exp_line : last_rd);
      chk("resp_no_read", burst_read, 0);
      chk("resp_no_write", burst_write, 0);
      if (is_rd) last_rd = exp_line;
      else mem[a[31:5]] = wd;
      line_read = 0;
      line_write = 0;
      tick();
      chk("resp_single", line_resp, 0);
      chk("idle_read", burst_read, 0);
      chk("idle_write", burst_write, 0);
   endtask

   initial begin
      logic [255:0] l;
      rst = 1;
      line_read = 0;
      line_write = 0;
      line_address = 0;
      line_wdata = 0;
      burst_rdata = 0;
      burst_resp = 0;
      tick();
      tick();
      rst = 0;
      chk("rst_line_resp", line_resp, 0);
      chk("rst_burst_read", burst_read, 0);
      chk("rst_burst_write", burst_write, 0);
      chk("rst_line_rdata", line_rdata, 0);
      chk("rst_burst_address", burst_address, 0);
      last_rd = 0;
      // read with known beats A0..A3, back-to-back responses
      mem[27'(32'h1234 >> 5)] = {64'hA3A3_0003_A3A3_0003, 64'hA2A2_0002_A2A2_0002,
                                 64'hA1A1_0001_A1A1_0001, 64'hA0A0_0000_A0A0_0000};
      req(1, 0, 32'h0000_1234, '0, -1, 0);
      // write with one gap after beat 1
      req(0, 1, 32'h0000_0080, {64'hD3, 64'hD2, 64'hD1, 64'hD0}, 2, 0);
      // read, write, read back-to-back
      req(1, 0, 32'h0000_0080, '0, -1, 0);
      req(0, 1, 32'h0000_0400, rand_line(), -1, 0);
      req(1, 0, 32'h0000_0400, '0, -1, 0);
      // reset after two beats of a read
      line_read = 1;
      line_address = 32'h40;
      tick();
      l = line_of(32'h40);
      for (int i = 0; i < 2; i++) begin
         burst_resp = 1;
         burst_rdata = l[64*i +: 64];
         tick();
      end
      burst_resp = 0;
      line_read = 0;
      rst = 1;
      tick();
      rst = 0;
      chk("abort_burst_read", burst_read, 0);
      chk("abort_burst_write", burst_write, 0);
      chk("abort_line_resp", line_resp, 0);
      chk("abort_line_rdata", line_rdata, 0);
      chk("abort_burst_address", burst_address, 0);
      last_rd = 0;
      req(1, 0, 32'h0000_0040, '0, -1, 0);
      // stray burst_resp while idle
      burst_resp = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stray_read", burst_read, 0);
         chk("stray_write", burst_write, 0);
         chk("stray_resp", line_resp, 0);
         chk("stray_rdata", line_rdata, last_rd);
      end
      burst_resp = 0;
      // simultaneous read and write: read wins, memory line left intact
      req(1, 1, 32'h0000_0080, rand_line(), -1, 0);
      req(1, 0, 32'h0000_0080, '0, -1, 0);
      // random traffic over a small address window
      for (int n = 0; n < 60; n++) begin
         logic [31:0] a;
         a = {22'b0, 5'($urandom_range(0, 15)), 5'($urandom)};
         if ($urandom_range(0, 1) == 1) req(1, 0, a, '0, -1, 1);
         else req(0, 1, a, rand_line(), -1, 1);
         for (int k = $urandom_range(0, 2); k > 0; k--) tick();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
